uart_byte_rx: RTL

Serial-to-byte receiver for the sensor bus link. It recovers 8N1 UART frames from the asynchronous bus RX pin using mid-bit majority sampling and flags framing errors. Each good byte is presented on `rx_data` with a one-cycle `rx_flag` pulse. It sits directly upstream of the bus-data parsing stage (`rxana`) and drives that stage's `rx_flag`/`rx_data` inputs.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/bit_sync.sv | 33 +++
 rtl/uart_byte_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg: shared UART receiver constants, state encoding, voting  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_CLK_DIV = 434;
  localparam int DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// +------------------------------------------------------------------+
// | bit_sync: two-flop synchronizer for an asynchronous input pin     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// +------------------------------------------------------------------+
// | uart_byte_rx: 8N1 UART receiver, mid-bit 2-of-3 majority sampling |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int              CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   SMP_A    = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]   SMP_B    = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]   SMP_C    = CW'(CLK_DIV / 2 + 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  logic            rxd_s;
  logic [1:0]      vld_q;
  logic            prev_q;
  logic            fall;
  logic            maj;
  logic            cnt_wrap;

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      smp_q, smp_d;
  logic [7:0]      data_q, data_d;
  logic            flag_q, flag_d;
  logic            err_q, err_d;

  bit_sync #(
    .RESET_VAL(1'b1)
  ) u_rxd_sync (
    .clk_i(sys_clk),
    .rst_i(sys_rst),
    .d_i  (uart_rxd),
    .q_o  (rxd_s)
  );

  // prev_q stays 0 until the synchronizer carries real line samples, so a
  // line that is low out of reset is never mistaken for a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_q  <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      vld_q  <= {vld_q[0], 1'b1};
      prev_q <= rxd_s & vld_q[1];
    end
  end

  assign fall     = prev_q & ~rxd_s;
  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign maj      = maj3(smp_q[1], smp_q[0], rxd_s);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      smp_q     <= '0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      smp_q     <= smp_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_wrap ? '0 : cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    smp_d     = smp_q;
    data_d    = data_q;
    flag_d    = 1'b0;
    err_d     = 1'b0;

    if (cnt_q == SMP_A) smp_d[1] = rxd_s;
    if (cnt_q == SMP_B) smp_d[0] = rxd_s;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == SMP_C && maj) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        // Right shift: first-received bit ends up in bit 0.
        if (cnt_q == SMP_C) shreg_d = {maj, shreg_q[7:1]};
        if (cnt_wrap) begin
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == SMP_C) begin
          cnt_d = '0;
          if (maj) begin
            data_d  = shreg_q;
            flag_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_flag   = flag_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

`default_nettype wire
